// File: rtl/stl_pkg.sv
// Shared definitions for the serial-to-TileLink bridge: packet layout, TL opcodes,
// response flag positions, FSM states and the request format check.
package stl_pkg;

  localparam int PKT_OPCODE_LSB = 0;
  localparam int PKT_SIZE_LSB   = 8;
  localparam int PKT_MASK_LSB   = 16;
  localparam int PKT_RSVD_LSB   = 24;
  localparam int PKT_ADDR_LSB   = 32;
  localparam int PKT_DATA_LSB   = 64;

  localparam logic [2:0] TL_PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  localparam int RSP_DENIED_BIT  = 16;
  localparam int RSP_CORRUPT_BIT = 17;
  localparam int RSP_FMT_ERR_BIT = 18;
  localparam int RSP_TIMEOUT_BIT = 19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE_A,
    ST_WAIT_D,
    ST_RESP
  } stl_state_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic [7:0]  mask;
    logic [31:0] addr;
    logic [63:0] data;
  } stl_req_t;

  // Bit-for-bit image of the 128-bit response packet, MSB first.
  typedef struct packed {
    logic [63:0] data;
    logic [31:0] addr;
    logic [11:0] zero;
    logic        timeout;
    logic        fmt_err;
    logic        corrupt;
    logic        denied;
    logic [7:0]  d_size;
    logic [7:0]  d_opcode;
  } stl_rsp_t;

  function automatic logic fmt_error(input logic [7:0]  opcode,
                                     input logic [7:0]  size,
                                     input logic [31:0] addr);
    logic [31:0] lsb_mask;
    if (opcode != {5'd0, TL_PUT_FULL_DATA} && opcode != {5'd0, TL_GET}) return 1'b1;
    if (size > 8'd3) return 1'b1;
    lsb_mask = (32'd1 << size[1:0]) - 32'd1;
    return (addr & lsb_mask) != 32'd0;
  endfunction

endpackage

// File: rtl/stl_timeout_counter.sv
// WAIT_D watchdog: counts enabled cycles since the last clear and flags the
// final cycle of the allowed window.
module stl_timeout_counter #(
  parameter int LIMIT = 100_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count_q, count_d;
  logic          at_limit;

  assign at_limit  = (count_q == CW'(LIMIT - 1));
  assign expired_o = enable_i && at_limit;

  always_comb begin
    count_d = count_q;
    if (clear_i)                    count_d = '0;
    else if (enable_i && !at_limit) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/stl_tl_master.sv
// Single-outstanding TL-UL master: turns one request packet into one A beat,
// waits for the matching D beat (or a timeout) and returns one response packet.
module stl_tl_master
  import stl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int SOURCE_ID      = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         packet_valid,
  output logic         packet_ready,
  input  logic [127:0] packet_data,
  output logic         tl_response_valid,
  input  logic         tl_response_ready,
  output logic [127:0] tl_response_data,
  output logic         a_valid,
  input  logic         a_ready,
  output logic [2:0]   a_opcode,
  output logic [2:0]   a_param,
  output logic [3:0]   a_size,
  output logic [3:0]   a_source,
  output logic [31:0]  a_address,
  output logic [7:0]   a_mask,
  output logic [63:0]  a_data,
  output logic         a_corrupt,
  input  logic         d_valid,
  output logic         d_ready,
  input  logic [2:0]   d_opcode,
  input  logic [3:0]   d_size,
  input  logic [3:0]   d_source,
  input  logic         d_denied,
  input  logic [63:0]  d_data,
  input  logic         d_corrupt
);

  stl_state_e state_q, state_d;
  stl_req_t   req_q, req_d;
  stl_rsp_t   rsp_q, rsp_d;
  logic       tmo_clear, tmo_enable, tmo_expired;
  logic       d_match;
  logic       unused_rsvd;

  assign unused_rsvd = ^packet_data[PKT_RSVD_LSB +: 8];
  assign d_match     = d_valid && (d_source == 4'(SOURCE_ID));

  stl_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk_i     (clk),
    .rst_i     (reset),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rsp_d      = rsp_q;
    tmo_clear  = 1'b0;
    tmo_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (packet_valid) begin
          req_d.opcode = packet_data[PKT_OPCODE_LSB +: 3];
          req_d.size   = packet_data[PKT_SIZE_LSB +: 4];
          req_d.mask   = packet_data[PKT_MASK_LSB +: 8];
          req_d.addr   = packet_data[PKT_ADDR_LSB +: 32];
          req_d.data   = packet_data[PKT_DATA_LSB +: 64];
          rsp_d        = '0;
          rsp_d.addr   = packet_data[PKT_ADDR_LSB +: 32];
          if (fmt_error(packet_data[PKT_OPCODE_LSB +: 8], packet_data[PKT_SIZE_LSB +: 8],
                        packet_data[PKT_ADDR_LSB +: 32])) begin
            rsp_d.fmt_err = 1'b1;
            state_d       = ST_RESP;
          end else begin
            state_d = ST_ISSUE_A;
          end
        end
      end
      ST_ISSUE_A: begin
        // Holding the counter clear here guarantees it starts at zero in WAIT_D.
        tmo_clear = 1'b1;
        if (a_ready) state_d = ST_WAIT_D;
      end
      ST_WAIT_D: begin
        tmo_enable = 1'b1;
        // A matching beat beats a coincident expiry; foreign-source beats are dropped.
        if (d_match) begin
          rsp_d          = '0;
          rsp_d.addr     = req_q.addr;
          rsp_d.d_opcode = {5'd0, d_opcode};
          rsp_d.d_size   = {4'd0, d_size};
          rsp_d.denied   = d_denied;
          rsp_d.corrupt  = d_corrupt;
          rsp_d.data     = (req_q.opcode == TL_GET) ? d_data : 64'd0;
          state_d        = ST_RESP;
        end else if (tmo_expired) begin
          rsp_d         = '0;
          rsp_d.addr    = req_q.addr;
          rsp_d.timeout = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tl_response_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
    end
  end

  // D is always drained outside ISSUE_A/RESP so late beats never stall the slave.
  assign packet_ready      = (state_q == ST_IDLE);
  assign d_ready           = (state_q == ST_IDLE) || (state_q == ST_WAIT_D);
  assign a_valid           = (state_q == ST_ISSUE_A);
  assign tl_response_valid = (state_q == ST_RESP);
  assign tl_response_data  = rsp_q;

  assign a_opcode  = req_q.opcode;
  assign a_param   = 3'd0;
  assign a_size    = req_q.size;
  assign a_source  = 4'(SOURCE_ID);
  assign a_address = req_q.addr;
  assign a_mask    = req_q.mask;
  assign a_data    = req_q.data;
  assign a_corrupt = 1'b0;

endmodule

// File: tb/tb_stl_tl_master.sv
// Randomized bench for stl_tl_master: host + TL slave driver, expectations from
// a transaction-level model of the packet/response rules.
module tb_stl_tl_master;

  localparam int         TMO = 16;
  localparam logic [3:0] SRC = 4'd2;

  logic         clk = 1'b0;
  logic         reset;
  logic         packet_valid, packet_ready;
  logic [127:0] packet_data;
  logic         tl_response_valid, tl_response_ready;
  logic [127:0] tl_response_data;
  logic         a_valid, a_ready;
  logic [2:0]   a_opcode, a_param;
  logic [3:0]   a_size, a_source;
  logic [31:0]  a_address;
  logic [7:0]   a_mask;
  logic [63:0]  a_data;
  logic         a_corrupt;
  logic         d_valid, d_ready;
  logic [2:0]   d_opcode;
  logic [3:0]   d_size, d_source;
  logic         d_denied, d_corrupt;
  logic [63:0]  d_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stl_tl_master #(.TIMEOUT_CYCLES(TMO), .SOURCE_ID(2)) dut (
    .clk(clk), .reset(reset),
    .packet_valid(packet_valid), .packet_ready(packet_ready), .packet_data(packet_data),
    .tl_response_valid(tl_response_valid), .tl_response_ready(tl_response_ready),
    .tl_response_data(tl_response_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit model_bad_fmt(input logic [7:0] op, input logic [7:0] sz,
                                       input logic [31:0] addr);
    if (!(op == 8'd0 || op == 8'd4)) return 1'b1;
    if (sz > 8'd3) return 1'b1;
    return (addr % (32'd1 << sz)) != 32'd0;
  endfunction

  // flags = {timeout, format error, corrupt, denied}
  function automatic logic [127:0] model_rsp(input logic [31:0] addr, input logic [3:0] flags,
                                             input logic [7:0] dop, input logic [7:0] dsz,
                                             input logic [63:0] data);
    return {data, addr, 12'd0, flags, dsz, dop};
  endfunction

  task automatic check_reset_outputs();
    chk("rst_pkt_ready", 128'(packet_ready), 1);
    chk("rst_a_valid",   128'(a_valid), 0);
    chk("rst_rsp_valid", 128'(tl_response_valid), 0);
    chk("rst_d_ready",   128'(d_ready), 1);
    chk("rst_rsp_data",  tl_response_data, 0);
    chk("rst_a_fields",  128'({a_opcode, a_size, a_address, a_mask, a_data}), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain_beat();
    chk("d_ready_idle", 128'(d_ready), 1);
    d_valid = 1'b1; d_source = SRC; d_opcode = 3'd1; d_data = 64'h0BAD_0BAD_0BAD_0BAD;
    @(negedge clk);
    d_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_no_rsp", 128'(tl_response_valid), 0);
      chk("drain_idle", 128'(packet_ready), 1);
      @(negedge clk);
    end
  endtask

  // d_dly: WAIT_D cycle on which the good D beat is offered (>= TMO means never).
  // rst_mode: 0 none, 1 reset in WAIT_D, 2 reset in RESP.
  task automatic do_txn(input logic [7:0] op, input logic [7:0] sz, input logic [7:0] mask,
                        input logic [31:0] addr, input logic [63:0] data, input logic [63:0] rd,
                        input int a_dly, input int d_dly, input int bad_at, input int rst_mode);
    bit           bad;
    logic         den, cor;
    logic [127:0] exp_rsp;
    logic [118:0] exp_a;
    int           got, exp_lat, hold;
    bad = model_bad_fmt(op, sz, addr);
    den = 1'($urandom);
    cor = 1'($urandom);
    chk("pkt_ready_idle", 128'(packet_ready), 1);
    packet_valid = 1'b1;
    packet_data  = {data, addr, 8'($urandom), mask, sz, op};
    @(negedge clk);
    packet_valid = 1'b0;
    if (bad) begin
      exp_rsp = model_rsp(addr, 4'b0100, 8'd0, 8'd0, 64'd0);
    end else begin
      exp_a = {op[2:0], 3'd0, sz[3:0], SRC, addr, mask, data, 1'b0};
      for (int i = 0; i <= a_dly; i++) begin
        chk("a_valid", 128'(a_valid), 1);
        chk("a_fields", 128'({a_opcode, a_param, a_size, a_source, a_address, a_mask,
                              a_data, a_corrupt}), 128'(exp_a));
        chk("pkt_ready_busy", 128'(packet_ready), 0);
        a_ready = (i == a_dly);
        @(negedge clk);
      end
      a_ready = 1'b0;
      chk("a_done", 128'(a_valid), 0);
      if (rst_mode == 1) begin
        pulse_reset();
        drain_beat();
        return;
      end
      got = -1;
      for (int n = 0; n <= TMO + 4; n++) begin
        if (tl_response_valid) begin
          got = n;
          break;
        end
        chk("d_ready_wait", 128'(d_ready), 1);
        d_valid   = (n == d_dly) || (n == bad_at);
        d_source  = (n == bad_at) ? 4'd5 : SRC;
        d_opcode  = (op == 8'd4) ? 3'd1 : 3'd0;
        d_size    = sz[3:0];
        d_denied  = den;
        d_corrupt = cor;
        d_data    = (n == bad_at) ? ~rd : rd;
        @(negedge clk);
      end
      d_valid = 1'b0;
      exp_lat = (d_dly < TMO) ? d_dly + 1 : TMO;
      chk("rsp_latency", 128'(got), 128'(exp_lat));
      if (d_dly < TMO)
        exp_rsp = model_rsp(addr, {2'b00, cor, den}, (op == 8'd4) ? 8'd1 : 8'd0, sz,
                            (op == 8'd4) ? rd : 64'd0);
      else
        exp_rsp = model_rsp(addr, 4'b1000, 8'd0, 8'd0, 64'd0);
    end
    if (rst_mode == 2) begin
      chk("rsp_before_rst", tl_response_data, exp_rsp);
      pulse_reset();
      return;
    end
    hold = $urandom_range(0, 2);
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", 128'(tl_response_valid), 1);
      chk("rsp_data", tl_response_data, exp_rsp);
      chk("pkt_ready_resp", 128'(packet_ready), 0);
      chk("a_quiet_resp", 128'(a_valid), 0);
      tl_response_ready = (i == hold);
      @(negedge clk);
    end
    tl_response_ready = 1'b0;
    chk("rsp_done", 128'(tl_response_valid), 0);
    chk("pkt_ready_back", 128'(packet_ready), 1);
    if (!bad && d_dly >= TMO) drain_beat();
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  op, sz, mask;
    logic [31:0] addr;
    logic [63:0] data, rd;
    int          kind, a_dly, d_dly, bad_at, rm;
    reset = 1'b1;
    packet_valid = 1'b0; packet_data = '0; tl_response_ready = 1'b0; a_ready = 1'b0;
    d_valid = 1'b0; d_opcode = '0; d_size = '0; d_source = '0; d_denied = 1'b0;
    d_data = '0; d_corrupt = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clk);

    do_txn(8'd4, 8'd2, 8'h0F, 32'h1000_0000, 64'd0, 64'hDEADBEEF, 0, 0, -1, 0);
    do_txn(8'd0, 8'd3, 8'hFF, 32'h0000_2000, 64'h1122334455667788, 64'h55, 5, 2, -1, 0);
    do_txn(8'd7, 8'd2, 8'h0F, 32'h0000_1000, 64'h1, 64'h0, 0, 0, -1, 0);
    do_txn(8'd4, 8'd2, 8'h0F, 32'h0000_1002, 64'h1, 64'h0, 0, 0, -1, 0);
    do_txn(8'd4, 8'd2, 8'h0F, 32'h0000_0100, 64'h0, 64'h77, 0, 99, -1, 0);
    do_txn(8'd4, 8'd3, 8'hFF, 32'h0000_0200, 64'h0, 64'hCAFE, 1, TMO - 1, -1, 0);
    do_txn(8'd4, 8'd1, 8'h03, 32'h0000_0302, 64'h0, 64'hABCD, 0, 4, 1, 0);
    do_txn(8'd0, 8'd2, 8'h0F, 32'h0000_0400, 64'h9, 64'h0, 0, 3, -1, 1);
    do_txn(8'd4, 8'd2, 8'h0F, 32'h0000_0500, 64'h0, 64'h1234, 0, 0, -1, 0);
    do_txn(8'd4, 8'd0, 8'h01, 32'h0000_0601, 64'h0, 64'h5678, 0, 1, -1, 2);
    do_txn(8'd0, 8'd0, 8'h01, 32'h0000_0701, 64'hEE, 64'h0, 2, 0, -1, 0);

    for (int t = 0; t < 40; t++) begin
      kind   = $urandom_range(0, 9);
      op     = ($urandom_range(0, 1) != 0) ? 8'd4 : 8'd0;
      sz     = 8'($urandom_range(0, 3));
      addr   = $urandom & ~((32'd1 << sz) - 32'd1);
      mask   = 8'($urandom);
      data   = {$urandom, $urandom};
      rd     = {$urandom, $urandom};
      a_dly  = $urandom_range(0, 4);
      d_dly  = $urandom_range(0, 6);
      bad_at = -1;
      rm     = 0;
      case (kind)
        0: do op = 8'($urandom); while (op == 8'd0 || op == 8'd4);
        1: sz = 8'($urandom_range(4, 255));
        2: begin
          sz   = 8'($urandom_range(1, 3));
          addr = ($urandom & ~((32'd1 << sz) - 32'd1)) | 32'($urandom_range(1, (1 << sz) - 1));
        end
        3: d_dly = $urandom_range(TMO, TMO + 3);
        4: d_dly = TMO - 1;
        5: begin
          d_dly  = $urandom_range(2, 14);
          bad_at = $urandom_range(0, d_dly - 1);
        end
        6: rm = 1;
        7: rm = 2;
        default: ;
      endcase
      do_txn(op, sz, mask, addr, data, rd, a_dly, d_dly, bad_at, rm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
